// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// instruction classes and the datapath select encodings.
package cu_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_LI   = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_BLT  = 6'b000011;
  localparam logic [5:0] OP_BGE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_IMM,
    C_LW,
    C_SW,
    C_BRANCH,
    C_JUMP,
    C_ILLEGAL
  } opclass_t;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_FUNC = 2'd2;
  localparam logic [1:0] ALU_SLT  = 2'd3;

  localparam logic [1:0] ASB_REGB = 2'd0;
  localparam logic [1:0] ASB_ONE  = 2'd1;
  localparam logic [1:0] ASB_IMM  = 2'd2;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control unit (slave) and the IR/memory/datapath side (master).
interface multicycle_control_fsm_if
  import cu_pkg::*;
#(
  parameter int ALUOP_W = 2
);
  // Memory handshake: mem_read/mem_write form a request that stays asserted,
  // with iord stable, until mem_ready is sampled high on a rising clk edge;
  // mem_ready is only meaningful while a request is outstanding.
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               mem_read;
  logic               mem_write;
  logic               iord;
  logic               ir_write;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               pc_write;
  logic               pc_write_cond;
  logic               branch_flip;
  logic [1:0]         pc_src;
  logic               illegal_op;
  logic               halted;
  state_t             dbg_state;
  logic [5:0]         dbg_op_q;

  modport master (
    output opcode, mem_ready,
    input  mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, branch_flip,
           pc_src, illegal_op, halted, dbg_state, dbg_op_q
  );

  modport slave (
    input  opcode, mem_ready,
    output mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, branch_flip,
           pc_src, illegal_op, halted, dbg_state, dbg_op_q
  );

endinterface

// File: rtl/multicycle_control_fsm_opclass_decode.sv
// Combinational opcode classifier; also yields the EXEC-state ALU operation
// and whether the branch condition is inverted.
module cu_opclass_decode
  import cu_pkg::*;
(
  input  logic [5:0] op,
  output opclass_t   cls,
  output logic [1:0] alu_op,
  output logic       branch_flip
);

  always_comb begin
    cls         = C_ILLEGAL;
    alu_op      = ALU_ADD;
    branch_flip = 1'b0;
    case (op)
      OP_R:    begin cls = C_RTYPE;  alu_op = ALU_FUNC; end
      OP_ADDI: begin cls = C_IMM;    alu_op = ALU_ADD;  end
      OP_LI:   begin cls = C_IMM;    alu_op = ALU_ADD;  end
      OP_SUBI: begin cls = C_IMM;    alu_op = ALU_SUB;  end
      OP_LW:   begin cls = C_LW;     alu_op = ALU_ADD;  end
      OP_SW:   begin cls = C_SW;     alu_op = ALU_ADD;  end
      OP_BEQ:  begin cls = C_BRANCH; alu_op = ALU_SUB;  end
      OP_BNE:  begin cls = C_BRANCH; alu_op = ALU_SUB; branch_flip = 1'b1; end
      OP_BLT:  begin cls = C_BRANCH; alu_op = ALU_SLT; branch_flip = 1'b1; end
      OP_BGE:  begin cls = C_BRANCH; alu_op = ALU_SLT;  end
      OP_J:    begin cls = C_JUMP;   alu_op = ALU_ADD;  end
      default: begin cls = C_ILLEGAL; end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory-wait timeout that parks the machine in HALT until reset.
module multicycle_control_fsm
  import cu_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  multicycle_control_fsm_if.slave bus
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic [7:0] wait_q, wait_d;
  logic [5:0] dec_op;
  opclass_t   cls;
  logic [1:0] dec_alu_op;
  logic       dec_flip;
  logic       mem_phase;
  logic       timeout_hit;

  // DECODE classifies the live opcode; later states reuse the latched copy.
  assign dec_op = (state_q == S_DECODE) ? bus.opcode : op_q;

  cu_opclass_decode u_dec (
    .op          (dec_op),
    .cls         (cls),
    .alu_op      (dec_alu_op),
    .branch_flip (dec_flip)
  );

  assign mem_phase   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout_hit = mem_phase && !bus.mem_ready && (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready)    state_d = S_DECODE;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_DECODE: state_d = (cls == C_ILLEGAL) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        case (cls)
          C_RTYPE, C_IMM: state_d = S_WB;
          C_LW, C_SW:     state_d = S_MEM;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)    state_d = (cls == C_LW) ? S_WB : S_FETCH;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // The counter only survives consecutive not-ready cycles in the same state.
  always_comb begin
    wait_d = '0;
    if (mem_phase && !bus.mem_ready && (state_d == state_q)) wait_d = wait_q + 8'd1;
  end

  logic       mem_read_c, mem_write_c, iord_c, ir_write_c, reg_write_c;
  logic       reg_dst_c, mem_to_reg_c, alu_src_a_c, pc_write_c, pc_write_cond_c;
  logic       branch_flip_c, illegal_op_c, halted_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_src_c;

  always_comb begin
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    iord_c          = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    reg_dst_c       = 1'b0;
    mem_to_reg_c    = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = ASB_REGB;
    alu_op_c        = ALU_ADD;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    branch_flip_c   = 1'b0;
    pc_src_c        = PCS_ALU;
    illegal_op_c    = 1'b0;
    halted_c        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = ASB_ONE;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
      end
      S_DECODE: illegal_op_c = (cls == C_ILLEGAL);
      S_EXEC: begin
        alu_op_c = dec_alu_op;
        case (cls)
          C_RTYPE: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = ASB_REGB;
          end
          C_IMM, C_LW, C_SW: alu_src_b_c = ASB_IMM;
          C_BRANCH: begin
            pc_write_cond_c = 1'b1;
            pc_src_c        = PCS_ALUOUT;
            branch_flip_c   = dec_flip;
          end
          C_JUMP: begin
            pc_write_c = 1'b1;
            pc_src_c   = PCS_JUMP;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        iord_c      = 1'b1;
        mem_read_c  = (cls == C_LW);
        mem_write_c = (cls == C_SW);
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = (cls == C_RTYPE);
        mem_to_reg_c = (cls == C_LW);
      end
      S_HALT:  halted_c = 1'b1;
      default: ;
    endcase
  end

  // Reset masks every output so an aborted MEM cycle never strobes a write.
  assign bus.mem_read      = !rst && mem_read_c;
  assign bus.mem_write     = !rst && mem_write_c;
  assign bus.iord          = !rst && iord_c;
  assign bus.ir_write      = !rst && ir_write_c;
  assign bus.reg_write     = !rst && reg_write_c;
  assign bus.reg_dst       = !rst && reg_dst_c;
  assign bus.mem_to_reg    = !rst && mem_to_reg_c;
  assign bus.alu_src_a     = !rst && alu_src_a_c;
  assign bus.alu_src_b     = rst ? 2'd0 : alu_src_b_c;
  assign bus.alu_op        = rst ? '0 : ALUOP_W'(alu_op_c);
  assign bus.pc_write      = !rst && pc_write_c;
  assign bus.pc_write_cond = !rst && pc_write_cond_c;
  assign bus.branch_flip   = !rst && branch_flip_c;
  assign bus.pc_src        = rst ? 2'd0 : pc_src_c;
  assign bus.illegal_op    = !rst && illegal_op_c;
  assign bus.halted        = !rst && halted_c;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_op_q      = op_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// cycle by cycle and compares the packed control word against hand values.
module tb_multicycle_control_fsm;
  import cu_pkg::*;

  // Packed control word bit positions, MSB = mem_read ... LSB = halted.
  localparam int MR  = 1 << 18;
  localparam int MW  = 1 << 17;
  localparam int IO  = 1 << 16;
  localparam int IRW = 1 << 15;
  localparam int RW  = 1 << 14;
  localparam int RD  = 1 << 13;
  localparam int M2R = 1 << 12;
  localparam int ASA = 1 << 11;
  localparam int PW  = 1 << 6;
  localparam int PWC = 1 << 5;
  localparam int BF  = 1 << 4;
  localparam int ILL = 1 << 1;
  localparam int HLT = 1;

  function automatic int asb(int v);  return v << 9; endfunction
  function automatic int aop(int v);  return v << 7; endfunction
  function automatic int psrc(int v); return v << 2; endfunction

  localparam int FETCH_RDY  = MR | (1 << 9) | IRW | PW;
  localparam int FETCH_WAIT = MR | (1 << 9);

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multicycle_control_fsm_if #(.ALUOP_W(2)) bus ();

  multicycle_control_fsm #(.ALUOP_W(2), .TIMEOUT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {13'd0, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_write, bus.pc_write_cond, bus.branch_flip, bus.pc_src,
            bus.illegal_op, bus.halted};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [5:0] op);
    bus.mem_ready = rdy;
    bus.opcode    = op;
    #1;
  endtask

  task automatic chk_cycle(input string tag, input int exp_ctl, input state_t exp_st);
    check({tag, "_ctl"}, ctl(), 32'(exp_ctl));
    check({tag, "_st"}, 32'(bus.dbg_state), 32'(exp_st));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_ADDI;
    adv();
    adv();
    check("reset_ctl", ctl(), 32'd0);
    check("reset_st", 32'(bus.dbg_state), 32'(S_FETCH));
    check("reset_opq", 32'(bus.dbg_op_q), 32'd0);
    rst = 1'b0;

    // ADDI, zero wait states: 4 cycles
    drive(1'b1, OP_ADDI); chk_cycle("addi_c1", FETCH_RDY, S_FETCH); adv();
    drive(1'b1, OP_ADDI); chk_cycle("addi_c2", 0, S_DECODE); adv();
    drive(1'b1, OP_ADDI); chk_cycle("addi_c3", asb(2) | aop(0), S_EXEC); adv();
    drive(1'b1, OP_ADDI); chk_cycle("addi_c4", RW, S_WB); adv();
    drive(1'b1, OP_ADDI); check("addi_end", 32'(bus.dbg_state), 32'(S_FETCH));

    // LW, two MEM wait cycles; ready arrives on the cycle the counter would hit TIMEOUT
    adv();
    drive(1'b1, OP_LW); chk_cycle("lw_dec", 0, S_DECODE); adv();
    drive(1'b1, OP_LW); chk_cycle("lw_exec", asb(2), S_EXEC); adv();
    drive(1'b0, OP_LW); chk_cycle("lw_mem1", MR | IO, S_MEM); adv();
    drive(1'b0, OP_LW); chk_cycle("lw_mem2", MR | IO, S_MEM); adv();
    drive(1'b1, OP_LW); chk_cycle("lw_mem3", MR | IO, S_MEM); adv();
    drive(1'b1, OP_LW); chk_cycle("lw_wb", RW | M2R, S_WB); adv();
    check("lw_end", 32'(bus.dbg_state), 32'(S_FETCH));

    // R-type; opcode changes after DECODE are ignored
    drive(1'b1, OP_R); chk_cycle("r_c1", FETCH_RDY, S_FETCH); adv();
    drive(1'b1, OP_R); adv();
    drive(1'b1, OP_LW); chk_cycle("r_exec", ASA | asb(0) | aop(2), S_EXEC); adv();
    drive(1'b1, OP_SW); chk_cycle("r_wb", RW | RD, S_WB); adv();

    // BNE then BGE: 3 cycles each
    drive(1'b1, OP_BNE); adv();
    drive(1'b1, OP_BNE); adv();
    drive(1'b1, OP_BNE); chk_cycle("bne_exec", aop(1) | PWC | psrc(1) | BF, S_EXEC); adv();
    drive(1'b1, OP_BGE); chk_cycle("bge_c1", FETCH_RDY, S_FETCH); adv();
    drive(1'b1, OP_BGE); adv();
    drive(1'b1, OP_BGE); chk_cycle("bge_exec", aop(3) | PWC | psrc(1), S_EXEC); adv();
    check("bge_end", 32'(bus.dbg_state), 32'(S_FETCH));

    // J
    adv();
    drive(1'b1, OP_J); adv();
    drive(1'b1, OP_J); chk_cycle("j_exec", PW | psrc(2), S_EXEC); adv();
    check("j_end", 32'(bus.dbg_state), 32'(S_FETCH));

    // Illegal opcode: single pulse in DECODE, back to FETCH
    adv();
    drive(1'b1, 6'b111111); chk_cycle("ill_dec", ILL, S_DECODE); adv();
    drive(1'b1, 6'b111111); chk_cycle("ill_next", FETCH_RDY, S_FETCH); adv();

    // SW, zero waits: 4 cycles
    drive(1'b1, OP_SW); adv();
    drive(1'b1, OP_SW); chk_cycle("sw_exec", asb(2), S_EXEC); adv();
    drive(1'b1, OP_SW); chk_cycle("sw_mem", MW | IO, S_MEM); adv();
    drive(1'b1, OP_SW); chk_cycle("sw_end", FETCH_RDY, S_FETCH); adv();

    // SW aborted by reset while its MEM request is outstanding
    drive(1'b1, OP_SW); adv();
    drive(1'b1, OP_SW); adv();
    drive(1'b0, OP_SW); chk_cycle("swr_mem", MW | IO, S_MEM);
    rst = 1'b1;
    #1;
    check("swr_rst_ctl", ctl(), 32'd0);
    adv();
    rst = 1'b0;
    drive(1'b1, OP_SW);
    chk_cycle("swr_after", FETCH_RDY, S_FETCH);
    check("swr_opq", 32'(bus.dbg_op_q), 32'd0);

    // FETCH timeout with TIMEOUT=3
    drive(1'b0, OP_ADDI); chk_cycle("to_w1", FETCH_WAIT, S_FETCH); adv();
    drive(1'b0, OP_ADDI); chk_cycle("to_w2", FETCH_WAIT, S_FETCH); adv();
    drive(1'b0, OP_ADDI); chk_cycle("to_w3", FETCH_WAIT, S_FETCH); adv();
    drive(1'b0, OP_ADDI); chk_cycle("to_halt", HLT, S_HALT); adv();
    drive(1'b1, OP_ADDI); chk_cycle("to_stay", HLT, S_HALT); adv();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    drive(1'b1, OP_ADDI); chk_cycle("to_reset", FETCH_RDY, S_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle control unit for the 8-bit datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives a shared instruction/data memory through a ready handshake. It replaces single-cycle decode with per-state datapath strobes, and adds a memory wait timeout plus illegal-opcode detection. It sits between the instruction register / memory interface and the datapath muxes, register file and ALU.

## Interface
Parameters:
- `ALUOP_W`, default 2: width of `alu_op`.
- `TIMEOUT`, default 15: maximum consecutive not-ready memory cycles before halt; range 1..255.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1: clock.
  - `rst`, in, 1: synchronous active-high reset.
- Instruction and memory inputs:
  - `opcode`, in, 6: instruction opcode from the IR bus. Sampled only in DECODE.
  - `mem_ready`, in, 1: memory has completed the current read or write.
- Memory and register strobes:
  - `mem_read`, out, 1: memory read request.
  - `mem_write`, out, 1: memory write request.
  - `iord`, out, 1: memory address select. 0 = PC, 1 = ALU result.
  - `ir_write`, out, 1: load the instruction register.
  - `reg_write`, out, 1: register file write enable.
- Datapath mux selects:
  - `reg_dst`, out, 1: destination register select. 1 = rd, 0 = rt.
  - `mem_to_reg`, out, 1: write-back source. 1 = memory data register, 0 = ALU out.
  - `alu_src_a`, out, 1: ALU A input. 0 = PC, 1 = register A.
  - `alu_src_b`, out, 2: ALU B input. 0 = register B, 1 = constant 1, 2 = immediate.
  - `alu_op`, out, `ALUOP_W`: ALU operation. 00 add, 01 sub, 10 func field, 11 slt.
- PC control:
  - `pc_write`, out, 1: unconditional PC load.
  - `pc_write_cond`, out, 1: conditional PC load; the datapath ANDs it with (zero XOR `branch_flip`).
  - `branch_flip`, out, 1: invert the branch condition.
  - `pc_src`, out, 2: PC source. 0 = ALU, 1 = ALU out (branch target), 2 = jump target.
- Status:
  - `illegal_op`, out, 1: one-cycle pulse on an unknown opcode.
  - `halted`, out, 1: high in HALT.

## Operation
States: FETCH, DECODE, EXEC, MEM, WB, HALT.

Opcode encoding:
- R = 000000
- ADDI = 001000
- SUBI = 001001
- LI = 001010
- BEQ = 000100
- BNE = 000001
- BLT = 000011
- BGE = 000101
- J = 000010
- LW = 100011
- SW = 101011

Per-state behaviour:
- **FETCH:**
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=00, `pc_src`=0.
  - On `mem_ready`: pulses `ir_write` and `pc_write`, then goes to DECODE.
- **DECODE:**
  - Latches `opcode` into an internal register `op_q`.
  - Any unknown opcode: pulses `illegal_op`, then goes to FETCH.
  - Any known opcode: goes to EXEC.
- **EXEC:** behaviour depends on `op_q`.
  - R: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=10; goes to WB.
  - ADDI and LI: `alu_src_b`=2, `alu_op`=00; goes to WB.
  - SUBI: `alu_src_b`=2, `alu_op`=01; goes to WB.
  - LW and SW: `alu_src_b`=2, `alu_op`=00; goes to MEM.
  - BEQ and BNE: `alu_op`=01, `pc_write_cond`=1, `pc_src`=1; goes to FETCH.
  - BLT and BGE: `alu_op`=11, `pc_write_cond`=1, `pc_src`=1; goes to FETCH.
  - `branch_flip`=1 for BNE and BLT.
  - J: `pc_write`=1, `pc_src`=2; goes to FETCH.
- **MEM:** `iord`=1.
  - LW: `mem_read`=1. On `mem_ready`, goes to WB.
  - SW: `mem_write`=1. On `mem_ready`, goes to FETCH.
- **WB:**
  - `reg_write`=1.
  - `reg_dst`=1 only for R.
  - `mem_to_reg`=1 only for LW.
  - Goes to FETCH.
- **HALT:**
  - All strobes 0 and `halted`=1.
  - Exits only via `rst`.

Output rules:
- Outputs are combinational from state and `op_q`.
- `ir_write`, and `pc_write` in FETCH, are additionally gated by `mem_ready`.
- Every output not listed for a state is 0.

## Timing
- Reset:
  - `rst` sampled high sets the state to FETCH and clears `op_q` and the wait counter.
  - While `rst` is high, all outputs are forced to 0.
- Latency with zero wait states: R / ADDI / SUBI / LI take 4 cycles, LW 5, SW 4, branches 3, J 3.
- Each memory wait cycle adds one cycle. Requests are held stable while `mem_ready`=0.
- Wait counter:
  - Increments on each FETCH or MEM cycle with `mem_ready`=0.
  - Clears on `mem_ready`=1 and on every state change.
  - When the counter reaches `TIMEOUT` and `mem_ready` is still 0, the next state is HALT.
  - `mem_ready` arriving in the same cycle the counter would hit `TIMEOUT` counts as success.
- `mem_ready` outside FETCH and MEM is ignored.
- `opcode` changes outside DECODE have no effect.
- `rst` asserted mid-instruction, including MEM with an outstanding request, aborts immediately. No write strobe is asserted in that cycle.

## Structure
- Shared package `cu_pkg` holds:
  - the opcode localparams;
  - the state enum;
  - the `alu_op`, `alu_src_b` and `pc_src` encodings.
- Sub-module `cu_opclass_decode` is combinational:
  - maps the 6-bit opcode to an instruction class (RTYPE, IMM, LW, SW, BRANCH, JUMP, ILLEGAL);
  - produces the EXEC `alu_op` and `branch_flip`;
  - is used in DECODE and EXEC.
- FSM, wait counter and output decode live in the top module.

## Test plan
- Reset then ADDI (001000), `mem_ready` tied 1:
  - FETCH `ir_write`/`pc_write` at cycle 1;
  - EXEC `alu_src_b`=2, `alu_op`=00 at cycle 3;
  - `reg_write`=1, `reg_dst`=0 at cycle 4.
- LW with 2 wait cycles in MEM:
  - `mem_read`=1 and `iord`=1 are held for 3 cycles;
  - WB then has `mem_to_reg`=1;
  - total 7 cycles.
- BNE (000001) then BGE (000101):
  - BNE EXEC gives `pc_write_cond`=1, `alu_op`=01, `branch_flip`=1;
  - BGE EXEC gives `alu_op`=11, `branch_flip`=0;
  - both return to FETCH after 3 cycles.
- Opcode 111111: `illegal_op` is a 1-cycle pulse in DECODE, followed by FETCH, with no write strobes.
- `TIMEOUT`=3, `mem_ready` held 0 in FETCH:
  - HALT is entered after 3 wait cycles, with `halted`=1 and all strobes 0;
  - `rst` then returns the FSM to FETCH.
- `rst` raised during SW MEM: the next cycle has `mem_write`=0, the state is FETCH and `op_q`=0.
